axi_mem_responder: RTL and testbench
====================================

// Module: axi_mem_responder
// PURPOSE
//  AXI4-MM slave backed by an internal byte-writable RAM. It is the far end of our
//  AXI-MM master engines: it answers AR bursts on the R channel and absorbs AW/W
//  bursts, acknowledging each on B. Used as a bench/loopback target and as a local
//  scratch memory behind the data-mover masters.
// PARAMETERS
//  DW    512   data width, bits (power of 2, >=32)
//  AW    64    address width, bits
//  IW    4     ID width, bits
//  DEPTH 1024  RAM depth in DW-bit words (power of 2)
// PORTS
//  clk            in   1       clock; all logic on rising edge
//  resetn         in   1       asynchronous, active-low reset
//  S_AXI_AWADDR   in   AW      write burst start address
//  S_AXI_AWLEN    in   8       beats-1
//  S_AXI_AWID     in   IW      write ID, echoed on BID
//  S_AXI_AWVALID  in   1       / S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   DW      / S_AXI_WSTRB in DW/8 / S_AXI_WLAST in 1
//  S_AXI_WVALID   in   1       / S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2       / S_AXI_BID out IW / S_AXI_BVALID out 1 / S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   AW      / S_AXI_ARLEN in 8 / S_AXI_ARID in IW
//  S_AXI_ARVALID  in   1       / S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  DW      / S_AXI_RRESP out 2 / S_AXI_RLAST out 1 / S_AXI_RID out IW
//  S_AXI_RVALID   out  1       / S_AXI_RREADY in 1
//  AxSIZE/AxBURST/AxLOCK/AxCACHE/AxPROT/AxQOS inputs present, ignored (INCR, full width)
//  reads_served   out  32      count of completed R bursts (wraps)
//  writes_served  out  32      count of completed B handshakes (wraps)
// BEHAVIOUR
//  Reset (async assert, sync release): all VALID/READY outputs 0, counters 0, FSMs idle.
//  Word index = (addr >> log2(DW/8)) mod DEPTH; index increments per beat, wraps at DEPTH.
//  Write FSM: W_IDLE (AWREADY=1) -AW hs-> W_DATA (WREADY=1) -WLAST hs-> W_RESP (BVALID=1)
//   -B hs-> W_IDLE. AWADDR/LEN/ID latched on AW hs. Each W hs writes bytes with WSTRB=1.
//  Beat counter 9 bits. BRESP=OKAY(0) if WLAST on beat AWLEN+1 exactly, else SLVERR(2).
//  Beats beyond AWLEN+1 before WLAST: accepted, not written. Early WLAST: ends burst.
//  Read FSM: R_IDLE (ARREADY=1) -AR hs-> R_FETCH -> R_SEND. First RVALID exactly 2
//   cycles after AR hs; then one beat/cycle while RREADY=1. RVALID/RDATA/RLAST stable
//   while RREADY=0. RLAST on beat ARLEN+1; RRESP=OKAY; RID=latched ARID. After last hs,
//   back to R_IDLE; ARREADY high again next cycle.
//  Read and write paths independent; one outstanding burst each. Same-word read and
//   write in one cycle: read returns old data.
//  Counters increment on RLAST hs / B hs respectively; 32-bit wrap 0xFFFFFFFF->0.
//  Reset mid-burst: outstanding burst abandoned, no B/R emitted; RAM contents kept.
// STRUCTURE
//  Shared package axi_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01.
//  Sub-module axi_resp_ram: simple dual-port RAM, DW wide, DEPTH deep, DW/8 byte
//   enables, 1-cycle registered read. FSMs, counters, ID latches in top.
// TESTING
//  1 AW addr 0x0 len 3, 4 W beats full strb, WLAST on 4th -> BVALID, BRESP=0, writes_served=1.
//  2 AR addr 0x0 len 3, RREADY=1 -> RVALID 2 cycles after AR hs, 4 back-to-back beats
//    match test 1 data, RLAST on beat 4, RID=ARID, reads_served=1.
//  3 RREADY toggled 1/0 each cycle during 16-beat read -> RDATA held while stalled, no loss.
//  4 Write at word DEPTH-2, len 3 -> beats land in words DEPTH-2,DEPTH-1,0,1; readback ok.
//  5 AWLEN=1, WLAST on beat 1 -> BRESP=2; AWLEN=1, WLAST on beat 3 -> beat 3 dropped, BRESP=2.
//  6 WSTRB=0x0F on one beat -> only bytes 0-3 change; resetn low mid-read -> RVALID=0 at once.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the memory responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_SEND
    } rd_state_e;

    // Byte-offset bits dropped from an address to form a word index.
    function automatic int unsigned word_shift(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4-MM bus bundle between a master engine and the memory responder.
interface axi_mem_responder_if #(
    parameter int DW = 512,
    parameter int AW = 64,
    parameter int IW = 4
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [7:0]      S_AXI_AWLEN;
    logic [IW-1:0]   S_AXI_AWID;
    logic [2:0]      S_AXI_AWSIZE;
    logic [1:0]      S_AXI_AWBURST;
    logic            S_AXI_AWLOCK;
    logic [3:0]      S_AXI_AWCACHE;
    logic [2:0]      S_AXI_AWPROT;
    logic [3:0]      S_AXI_AWQOS;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;

    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WLAST;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;

    logic [1:0]      S_AXI_BRESP;
    logic [IW-1:0]   S_AXI_BID;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;

    logic [AW-1:0]   S_AXI_ARADDR;
    logic [7:0]      S_AXI_ARLEN;
    logic [IW-1:0]   S_AXI_ARID;
    logic [2:0]      S_AXI_ARSIZE;
    logic [1:0]      S_AXI_ARBURST;
    logic            S_AXI_ARLOCK;
    logic [3:0]      S_AXI_ARCACHE;
    logic [2:0]      S_AXI_ARPROT;
    logic [3:0]      S_AXI_ARQOS;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;

    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RLAST;
    logic [IW-1:0]   S_AXI_RID;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWID, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWVALID,
               S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY,
               S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARID, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARVALID,
               S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID,
               S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWID, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWVALID,
               S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY,
               S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARID, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARVALID,
               S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BID, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID,
               S_AXI_RVALID
    );

endinterface

// File: rtl/axi_resp_ram.sv
// Simple dual-port RAM with byte enables and a registered read port.
// The read register holds its value while re_i is low, so it can drive RDATA directly.
module axi_resp_ram #(
    parameter  int DW    = 512,
    parameter  int DEPTH = 1024,
    localparam int IDXW  = $clog2(DEPTH),
    localparam int BW    = DW / 8
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [IDXW-1:0] waddr_i,
    input  logic [BW-1:0]   wstrb_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            re_i,
    input  logic [IDXW-1:0] raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BW; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4-MM slave backed by a byte-writable RAM: INCR bursts, one outstanding
// read and one outstanding write, independent paths.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int DW    = 512,
    parameter int AW    = 64,
    parameter int IW    = 4,
    parameter int DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    axi_mem_responder_if.slave   s_axi,
    output logic [31:0]          reads_served,
    output logic [31:0]          writes_served
);

    localparam int OFFW = int'(word_shift(DW));
    localparam int IDXW = $clog2(DEPTH);
    localparam int BW   = DW / 8;

    // ---------------- write path ----------------
    wr_state_e       wr_state_q;
    logic            awready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q;
    logic [IW-1:0]   bid_q;
    logic [IDXW-1:0] wr_idx_q;
    logic [7:0]      wr_len_q;
    logic [8:0]      wr_cnt_q, wr_cnt_d;
    logic [31:0]     writes_q;
    logic            aw_hs, w_hs, b_hs, ram_we;

    assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs   = s_axi.S_AXI_WVALID & wready_q;
    assign b_hs   = bvalid_q & s_axi.S_AXI_BREADY;
    // Saturate so a runaway burst can never wrap back into the writable range.
    assign wr_cnt_d = (wr_cnt_q == 9'h1FF) ? wr_cnt_q : wr_cnt_q + 9'd1;
    assign ram_we   = w_hs & (wr_cnt_q <= {1'b0, wr_len_q});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            bid_q      <= '0;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            writes_q   <= '0;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_idx_q   <= s_axi.S_AXI_AWADDR[OFFW +: IDXW];
                        wr_len_q   <= s_axi.S_AXI_AWLEN;
                        bid_q      <= s_axi.S_AXI_AWID;
                        wr_cnt_q   <= '0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_idx_q <= wr_idx_q + IDXW'(1);
                        wr_cnt_q <= wr_cnt_d;
                        if (s_axi.S_AXI_WLAST) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= (wr_cnt_q == {1'b0, wr_len_q}) ? RESP_OKAY : RESP_SLVERR;
                            wr_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        writes_q   <= writes_q + 32'd1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rd_state_e       rd_state_q;
    logic            arready_q, rvalid_q, rlast_q;
    logic [IW-1:0]   rid_q;
    logic [IDXW-1:0] rd_idx_q, ram_raddr;
    logic [7:0]      rd_left_q;
    logic [31:0]     reads_q;
    logic            ar_hs, r_hs, ram_re;
    logic [DW-1:0]   ram_rdata;

    assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;
    assign r_hs  = rvalid_q & s_axi.S_AXI_RREADY;
    // Prefetch the next beat only when the current one is accepted; otherwise
    // the RAM read register holds RDATA steady through a stall.
    assign ram_re    = (rd_state_q == R_FETCH) | ((rd_state_q == R_SEND) & r_hs & ~rlast_q);
    assign ram_raddr = (rd_state_q == R_SEND) ? rd_idx_q + IDXW'(1) : rd_idx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rd_idx_q   <= '0;
            rd_left_q  <= '0;
            reads_q    <= '0;
        end else begin
            unique case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_idx_q   <= s_axi.S_AXI_ARADDR[OFFW +: IDXW];
                        rd_left_q  <= s_axi.S_AXI_ARLEN;
                        rid_q      <= s_axi.S_AXI_ARID;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_FETCH;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rvalid_q   <= 1'b1;
                    rlast_q    <= (rd_left_q == 8'd0);
                    rd_state_q <= R_SEND;
                end
                R_SEND: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            arready_q  <= 1'b1;
                            reads_q    <= reads_q + 32'd1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_idx_q  <= rd_idx_q + IDXW'(1);
                            rd_left_q <= rd_left_q - 8'd1;
                            rlast_q   <= (rd_left_q == 8'd1);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    axi_resp_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_idx_q),
        .wstrb_i (s_axi.S_AXI_WSTRB),
        .wdata_i (s_axi.S_AXI_WDATA),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_BID     = bid_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = ram_rdata;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;
    assign s_axi.S_AXI_RID     = rid_q;
    assign reads_served        = reads_q;
    assign writes_served       = writes_q;

    // Attribute signals are accepted but have no effect (INCR, full width only).
    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR,
                         s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST ^ BURST_INCR, s_axi.S_AXI_AWLOCK,
                         s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWPROT, s_axi.S_AXI_AWQOS,
                         s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST ^ BURST_INCR, s_axi.S_AXI_ARLOCK,
                         s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARQOS};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized scoreboard bench for axi_mem_responder against an array memory model.
module tb_axi_mem_responder;
    import axi_pkg::*;

    localparam int DW = 64, AW = 32, IW = 4, DEPTH = 16, BW = DW / 8;

    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;

    axi_mem_responder_if #(.DW(DW), .AW(AW), .IW(IW)) bus ();
    logic [31:0] reads_served, writes_served;

    axi_mem_responder #(.DW(DW), .AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi         (bus),
        .reads_served  (reads_served),
        .writes_served (writes_served)
    );

    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic last; } r_exp_t;

    b_exp_t        bq[$];
    r_exp_t        rq[$];
    logic [DW-1:0] mem [DEPTH];
    int checks = 0, failures = 0;
    int exp_reads = 0, exp_writes = 0;
    int cyc = 0, ar_hs_cyc = 0, rr_mode = 0;
    bit first_pending = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_hs(input int ch, input string nm);
        int g = 0;
        forever begin
            @(negedge clk);
            if ((ch == 0 && bus.S_AXI_AWREADY) || (ch == 1 && bus.S_AXI_WREADY) ||
                (ch == 2 && bus.S_AXI_ARREADY)) break;
            if (++g > 200) begin
                checks++; failures++;
                $display("FAIL %s_timeout: ready not seen in 200 cycles", nm);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int len, input int nbeats,
                            input logic [BW-1:0] strb, input bit rnd_strb);
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        logic [BW-1:0] st;
        int idx;
        id  = IW'($urandom);
        idx = int'((addr >> 3) % DEPTH);
        @(posedge clk); #1;
        bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = 8'(len); bus.S_AXI_AWID = id;
        bus.S_AXI_AWVALID = 1'b1;
        wait_hs(0, "aw");
        bus.S_AXI_AWVALID = 1'b0;
        bq.push_back('{id: id, resp: (nbeats == len + 1) ? RESP_OKAY : RESP_SLVERR});
        for (int i = 0; i < nbeats; i++) begin
            d  = {$urandom, $urandom};
            st = rnd_strb ? BW'($urandom) : strb;
            bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = st;
            bus.S_AXI_WLAST = (i == nbeats - 1); bus.S_AXI_WVALID = 1'b1;
            wait_hs(1, "w");
            if (i <= len)
                for (int b = 0; b < BW; b++)
                    if (st[b]) mem[(idx + i) % DEPTH][b*8 +: 8] = d[b*8 +: 8];
            if ($urandom_range(0, 3) == 0) begin
                bus.S_AXI_WVALID = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len);
        logic [IW-1:0] id;
        int idx;
        id  = IW'($urandom);
        idx = int'((addr >> 3) % DEPTH);
        for (int i = 0; i <= len; i++)
            rq.push_back('{id: id, data: mem[(idx + i) % DEPTH], last: (i == len)});
        @(posedge clk); #1;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = 8'(len); bus.S_AXI_ARID = id;
        bus.S_AXI_ARVALID = 1'b1;
        wait_hs(2, "ar");
        bus.S_AXI_ARVALID = 1'b0;
        ar_hs_cyc = cyc;
        first_pending = 1'b1;
    endtask

    task automatic drain_and_count(input string nm);
        int g = 0;
        while (bq.size() != 0 || rq.size() != 0) begin
            @(negedge clk);
            if (++g > 2000) begin
                checks++; failures++;
                $display("FAIL %s_drain: %0d B and %0d R responses never arrived", nm, bq.size(), rq.size());
                bq.delete(); rq.delete();
            end
        end
        @(negedge clk);
        check({nm, "_writes_served"}, 64'(writes_served), 64'(exp_writes));
        check({nm, "_reads_served"}, 64'(reads_served), 64'(exp_reads));
    endtask

    // Ready drivers for the response channels.
    initial begin
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       bus.S_AXI_RREADY = 1'b1;
                1:       bus.S_AXI_RREADY = ~bus.S_AXI_RREADY;
                default: bus.S_AXI_RREADY = 1'($urandom_range(0, 1));
            endcase
            bus.S_AXI_BREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every R and B handshake against the scoreboard queues.
    initial begin
        r_exp_t re;
        b_exp_t be;
        bit prev_stall = 0, last_seen = 0;
        logic [DW-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 0; last_seen = 0; first_pending = 0;
                continue;
            end
            if (last_seen) begin
                check("arready_after_rlast", 64'(bus.S_AXI_ARREADY), 64'd1);
                last_seen = 0;
            end
            if (prev_stall) begin
                check("rvalid_hold", 64'(bus.S_AXI_RVALID), 64'd1);
                check("rdata_hold", bus.S_AXI_RDATA, prev_data);
            end
            if (bus.S_AXI_RVALID && first_pending) begin
                // first sampled-high edge must be the second edge after the AR handshake
                check("r_first_latency", 64'(cyc + 1), 64'(ar_hs_cyc + 2));
                first_pending = 0;
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected: beat with data %h and no read outstanding", bus.S_AXI_RDATA);
                end else begin
                    re = rq.pop_front();
                    check("rdata", bus.S_AXI_RDATA, re.data);
                    check("rid", 64'(bus.S_AXI_RID), 64'(re.id));
                    check("rlast", 64'(bus.S_AXI_RLAST), 64'(re.last));
                    check("rresp", 64'(bus.S_AXI_RRESP), 64'(RESP_OKAY));
                    if (re.last) begin exp_reads++; last_seen = 1; end
                end
            end
            prev_stall = bus.S_AXI_RVALID && !bus.S_AXI_RREADY;
            prev_data  = bus.S_AXI_RDATA;
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected: response %0d with no write outstanding", bus.S_AXI_BRESP);
                end else begin
                    be = bq.pop_front();
                    check("bid", 64'(bus.S_AXI_BID), 64'(be.id));
                    check("bresp", 64'(bus.S_AXI_BRESP), 64'(be.resp));
                    exp_writes++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_AWSIZE = 3'd3; bus.S_AXI_AWBURST = BURST_INCR; bus.S_AXI_AWLOCK = 1'b0;
        bus.S_AXI_AWCACHE = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWQOS = '0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_ARSIZE = 3'd3; bus.S_AXI_ARBURST = BURST_INCR; bus.S_AXI_ARLOCK = 1'b0;
        bus.S_AXI_ARCACHE = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARQOS = '0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
        check("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd0);
        check("rst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        check("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
        check("rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
        check("rst_counters", {reads_served, writes_served}, 64'd0);
        resetn = 1'b1;

        // fill every word so the model is fully known
        do_write(32'h0, DEPTH - 1, DEPTH, '1, 0);
        drain_and_count("init");

        do_write(32'h0, 3, 4, '1, 0);                   // basic 4-beat write
        drain_and_count("t1");
        rr_mode = 0;
        do_read(32'h0, 3);                               // back-to-back readback
        drain_and_count("t2");

        rr_mode = 1;
        do_read(32'h40, 15);                             // stalled 16-beat read, wraps
        drain_and_count("t3");

        rr_mode = 0;
        do_write((DEPTH - 2) * 8, 3, 4, '1, 0);          // write wraps past DEPTH-1
        drain_and_count("t4w");
        do_read((DEPTH - 2) * 8, 3);
        drain_and_count("t4r");

        do_write(32'h20, 1, 1, '1, 0);                   // early WLAST
        drain_and_count("t5a");
        do_write(32'h50, 1, 3, '1, 0);                   // overlong burst
        drain_and_count("t5b");
        do_read(32'h20, 7);
        drain_and_count("t5r");

        do_write(32'h18, 0, 1, 8'h0F, 0);                // partial strobe
        drain_and_count("t6w");
        do_read(32'h18, 0);
        drain_and_count("t6r");

        rr_mode = 2;
        for (int n = 0; n < 12; n++) begin
            int len, nb;
            len = $urandom_range(0, 7);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : len + 1;
            do_write($urandom, len, nb, '1, 1);
            drain_and_count("rnd_w");
            do_read($urandom, $urandom_range(0, 15));
            drain_and_count("rnd_r");
        end

        // reset in the middle of a read burst
        rr_mode = 1;
        do_read(32'h0, 15);
        for (int g = 0; g < 20 && !bus.S_AXI_RVALID; g++) @(negedge clk);
        @(negedge clk);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("midrst_rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
        check("midrst_reads_served", 64'(reads_served), 64'd0);
        check("midrst_writes_served", 64'(writes_served), 64'd0);
        rq.delete(); bq.delete();
        exp_reads = 0; exp_writes = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        rr_mode = 0;
        do_read(32'h0, DEPTH - 1);                       // RAM contents survive reset
        drain_and_count("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
